// File: rtl/pad_attr_pkg.sv
// pad_attr_pkg: shared widths, pad counts, attribute type, WARL mask and FSM states
// for the pad attribute sequencer.
package pad_attr_pkg;
   localparam int unsigned AttrDw   = 10;
   localparam int unsigned NMioPads = 32;
   localparam int unsigned NDioPads = 15;
   localparam int unsigned NPads    = NMioPads + NDioPads;

   typedef logic [AttrDw-1:0] pad_attr_t;

   localparam pad_attr_t DefaultWarlMask = '1;

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, RESP, SWEEP} state_e;
endpackage

// File: rtl/pad_attr_settle_cnt.sv
// pad_attr_settle_cnt: loadable down-counter; done_o is high while the count is zero.
module pad_attr_settle_cnt #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             done_o
);
   logic [Width-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - Width'(1) : cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else cnt_q <= cnt_d;

   assign done_o = (cnt_q == '0);
endmodule

// File: rtl/pad_attr_sequencer.sv
// pad_attr_sequencer: owns MIO/DIO pad attribute vectors; masked single-pad writes with settle
// delay and a default sweep. Optional sticky lock via PAD_ATTR_SEQ_LOCK_EN.
module pad_attr_sequencer
   import pad_attr_pkg::*;
#(
   parameter int unsigned SettleCycles = 4,
   parameter pad_attr_t   WarlMask     = DefaultWarlMask,
   parameter pad_attr_t   DefaultAttr  = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic                       req_is_dio_i,
   input  logic [5:0]                 req_idx_i,
   input  logic [AttrDw-1:0]          req_attr_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [AttrDw-1:0]          rsp_attr_o,
   output logic                       rsp_err_o,
   input  logic                       sweep_start_i,
   output logic                       sweep_done_o,
   output logic                       busy_o,
`ifdef PAD_ATTR_SEQ_LOCK_EN
   input  logic                       lock_i,
   output logic                       locked_o,
`endif
   output logic [NMioPads*AttrDw-1:0] mio_attr_o,
   output logic [NDioPads*AttrDw-1:0] dio_attr_o
);
   localparam pad_attr_t  ResetAttr  = DefaultAttr & WarlMask;
   localparam logic [7:0] SettleLoad = 8'((SettleCycles >= 2) ? SettleCycles - 2 : 0);

   state_e     state_q, state_d;
   pad_attr_t  mio_q [NMioPads], mio_d [NMioPads];
   pad_attr_t  dio_q [NDioPads], dio_d [NDioPads];
   pad_attr_t  rsp_attr_q, rsp_attr_d, masked, cur_attr;
   logic       rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic       sweep_done_q, sweep_done_d, cnt_load, cnt_done, idx_ok, locked;
   logic [5:0] sweep_cnt_q, sweep_cnt_d;

   assign masked      = req_attr_i & WarlMask;
   assign idx_ok      = req_is_dio_i ? (req_idx_i < 6'(NDioPads)) : (req_idx_i < 6'(NMioPads));
   assign req_ready_o = (state_q == IDLE) && !sweep_start_i;

`ifdef PAD_ATTR_SEQ_LOCK_EN
   logic lock_q, lock_d;
   assign lock_d   = lock_q | lock_i;
   assign locked   = lock_q;
   assign locked_o = lock_q;
   assign cur_attr = !idx_ok ? '0 : req_is_dio_i ? dio_q[req_idx_i[3:0]] : mio_q[req_idx_i[4:0]];
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) lock_q <= 1'b0;
      else lock_q <= lock_d;
`else
   assign locked   = 1'b0;
   assign cur_attr = '0;
`endif

   pad_attr_settle_cnt #(.Width(8)) u_settle_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (cnt_load),
      .load_val_i (SettleLoad),
      .done_o     (cnt_done)
   );

   always_comb begin
      state_d      = state_q;
      mio_d        = mio_q;
      dio_d        = dio_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_err_d    = rsp_err_q;
      rsp_attr_d   = rsp_attr_q;
      sweep_done_d = 1'b0;
      sweep_cnt_d  = sweep_cnt_q;
      cnt_load     = 1'b0;
      case (state_q)
         IDLE:
            if (sweep_start_i && !locked) begin
               state_d     = SWEEP;
               sweep_cnt_d = '0;
            end else if (req_valid_i && req_ready_o) begin
               rsp_err_d  = locked || !idx_ok;
               rsp_attr_d = locked ? cur_attr : idx_ok ? masked : '0;
               if (locked || !idx_ok) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
               end else begin
                  if (req_is_dio_i) dio_d[req_idx_i[3:0]] = masked;
                  else mio_d[req_idx_i[4:0]] = masked;
                  state_d     = (SettleCycles == 0) ? RESP : APPLY;
                  rsp_valid_d = (SettleCycles == 0);
               end
            end
         // APPLY already counts as the first settle cycle
         APPLY: begin
            state_d     = (SettleCycles <= 1) ? RESP : SETTLE;
            rsp_valid_d = (SettleCycles <= 1);
            cnt_load    = (SettleCycles > 1);
         end
         SETTLE:
            if (cnt_done) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
            end
         RESP:
            if (rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         SWEEP: begin
            if (sweep_cnt_q < 6'(NMioPads)) mio_d[sweep_cnt_q[4:0]] = ResetAttr;
            else dio_d[4'(sweep_cnt_q - 6'(NMioPads))] = ResetAttr;
            if (sweep_cnt_q == 6'(NPads - 1)) begin
               state_d      = IDLE;
               sweep_done_d = 1'b1;
            end else sweep_cnt_d = sweep_cnt_q + 6'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q      <= IDLE;
         for (int i = 0; i < NMioPads; i++) mio_q[i] <= ResetAttr;
         for (int i = 0; i < NDioPads; i++) dio_q[i] <= ResetAttr;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_attr_q   <= '0;
         sweep_done_q <= 1'b0;
         sweep_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         mio_q        <= mio_d;
         dio_q        <= dio_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_attr_q   <= rsp_attr_d;
         sweep_done_q <= sweep_done_d;
         sweep_cnt_q  <= sweep_cnt_d;
      end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_err_o    = rsp_err_q;
   assign rsp_attr_o   = rsp_attr_q;
   assign sweep_done_o = sweep_done_q;
   assign busy_o       = (state_q != IDLE);

   for (genvar k = 0; k < NMioPads; k++) begin : g_mio
      assign mio_attr_o[k*AttrDw +: AttrDw] = mio_q[k];
   end
   for (genvar k = 0; k < NDioPads; k++) begin : g_dio
      assign dio_attr_o[k*AttrDw +: AttrDw] = dio_q[k];
   end
endmodule

// File: tb/tb_pad_attr_sequencer.sv
// tb_pad_attr_sequencer: directed bench with WarlMask=0x0FF, DefaultAttr=0x155, SettleCycles=4.
module tb_pad_attr_sequencer;
   import pad_attr_pkg::*;

   localparam pad_attr_t DefM = 10'h055;

   logic      clk_i = 1'b0, rst_ni = 1'b0;
   logic      req_valid_i = 1'b0, req_is_dio_i = 1'b0, rsp_ready_i = 1'b0, sweep_start_i = 1'b0;
   logic [5:0] req_idx_i = '0;
   pad_attr_t req_attr_i = '0;
   logic      req_ready_o, rsp_valid_o, rsp_err_o, sweep_done_o, busy_o;
   pad_attr_t rsp_attr_o;
   logic [NMioPads*AttrDw-1:0] mio_attr_o, exp_mio;
   logic [NDioPads*AttrDw-1:0] dio_attr_o, exp_dio;
`ifdef PAD_ATTR_SEQ_LOCK_EN
   logic lock_i = 1'b0, locked_o;
`endif
   int chk_cnt = 0, pass_cnt = 0;

   always #5 clk_i = ~clk_i;

   pad_attr_sequencer #(.SettleCycles(4), .WarlMask(10'h0FF), .DefaultAttr(10'h155)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_is_dio_i(req_is_dio_i),
      .req_idx_i(req_idx_i), .req_attr_i(req_attr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_attr_o(rsp_attr_o), .rsp_err_o(rsp_err_o),
      .sweep_start_i(sweep_start_i), .sweep_done_o(sweep_done_o), .busy_o(busy_o),
`ifdef PAD_ATTR_SEQ_LOCK_EN
      .lock_i(lock_i), .locked_o(locked_o),
`endif
      .mio_attr_o(mio_attr_o), .dio_attr_o(dio_attr_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_defaults();
      exp_mio = {NMioPads{DefM}};
      exp_dio = {NDioPads{DefM}};
   endtask

   task automatic wait_rsp_ack(input string nm, input logic exp_err, input pad_attr_t exp_attr);
      int n = 0;
      while (!rsp_valid_o && n < 20) begin tick(); n++; end
      chk_cnt++; if (rsp_valid_o !== 1'b1) $display("FAIL %s_rsp_valid got=%b want=1", nm, rsp_valid_o); else pass_cnt++;
      chk_cnt++; if ({rsp_err_o, rsp_attr_o} !== {exp_err, exp_attr}) $display("FAIL %s_rsp got err=%b attr=%h want err=%b attr=%h", nm, rsp_err_o, rsp_attr_o, exp_err, exp_attr); else pass_cnt++;
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
   endtask

   task automatic write_ack(input logic dio, input logic [5:0] idx, input pad_attr_t attr, input logic exp_err, input pad_attr_t exp_attr, input string nm);
      req_valid_i = 1'b1; req_is_dio_i = dio; req_idx_i = idx; req_attr_i = attr;
      tick();
      req_valid_i = 1'b0;
      wait_rsp_ack(nm, exp_err, exp_attr);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      set_defaults();
      tick(); tick();
      chk_cnt++; if (mio_attr_o !== exp_mio) $display("FAIL reset_mio got=%h want=%h", mio_attr_o, exp_mio); else pass_cnt++;
      chk_cnt++; if (dio_attr_o !== exp_dio) $display("FAIL reset_dio got=%h want=%h", dio_attr_o, exp_dio); else pass_cnt++;
      chk_cnt++; if ({busy_o, rsp_valid_o, rsp_err_o, sweep_done_o, req_ready_o} !== 5'b00001) $display("FAIL reset_ctrl got=%b want=00001", {busy_o, rsp_valid_o, rsp_err_o, sweep_done_o, req_ready_o}); else pass_cnt++;
      chk_cnt++; if (rsp_attr_o !== 10'h000) $display("FAIL reset_rsp_attr got=%h want=000", rsp_attr_o); else pass_cnt++;
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_mio_write();
      req_valid_i = 1'b1; req_is_dio_i = 1'b0; req_idx_i = 6'd5; req_attr_i = 10'h3FF;
      #1;
      chk_cnt++; if (req_ready_o !== 1'b1) $display("FAIL mio_ready got=%b want=1", req_ready_o); else pass_cnt++;
      tick();
      req_valid_i = 1'b0;
      exp_mio[5*AttrDw +: AttrDw] = 10'h0FF;
      chk_cnt++; if (mio_attr_o !== exp_mio) $display("FAIL mio_slot_n1 got=%h want=%h", mio_attr_o, exp_mio); else pass_cnt++;
      chk_cnt++; if ({busy_o, rsp_valid_o} !== 2'b10) $display("FAIL mio_n1_ctrl got=%b want=10", {busy_o, rsp_valid_o}); else pass_cnt++;
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL mio_rsp_early_n%0d got=%b want=0", i, rsp_valid_o); else pass_cnt++;
      end
      tick();
      chk_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_attr_o} !== {2'b10, 10'h0FF}) $display("FAIL mio_rsp_n5 got v=%b e=%b a=%h want v=1 e=0 a=0ff", rsp_valid_o, rsp_err_o, rsp_attr_o); else pass_cnt++;
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk_cnt++; if ({rsp_valid_o, busy_o, req_ready_o} !== 3'b001) $display("FAIL mio_idle_after got=%b want=001", {rsp_valid_o, busy_o, req_ready_o}); else pass_cnt++;
   endtask

   task automatic test_dio_err();
      req_valid_i = 1'b1; req_is_dio_i = 1'b1; req_idx_i = 6'd15; req_attr_i = 10'h3AA;
      tick();
      req_valid_i = 1'b0;
      chk_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_attr_o} !== {2'b11, 10'h000}) $display("FAIL dio_err_n1 got v=%b e=%b a=%h want v=1 e=1 a=000", rsp_valid_o, rsp_err_o, rsp_attr_o); else pass_cnt++;
      chk_cnt++; if ({mio_attr_o, dio_attr_o} !== {exp_mio, exp_dio}) $display("FAIL dio_err_slots got=%h want=%h", {mio_attr_o, dio_attr_o}, {exp_mio, exp_dio}); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_attr_o, req_ready_o} !== {2'b11, 10'h000, 1'b0}) $display("FAIL dio_err_hold%0d got v=%b e=%b a=%h rdy=%b want 1 1 000 0", i, rsp_valid_o, rsp_err_o, rsp_attr_o, req_ready_o); else pass_cnt++;
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      write_ack(1'b0, 6'd32, 10'h011, 1'b1, 10'h000, "mio_oob");
      chk_cnt++; if (mio_attr_o !== exp_mio) $display("FAIL mio_oob_slots got=%h want=%h", mio_attr_o, exp_mio); else pass_cnt++;
   endtask

   task automatic test_dio_write();
      write_ack(1'b1, 6'd14, 10'h2C3, 1'b0, 10'h0C3, "dio14");
      exp_dio[14*AttrDw +: AttrDw] = 10'h0C3;
      chk_cnt++; if ({mio_attr_o, dio_attr_o} !== {exp_mio, exp_dio}) $display("FAIL dio14_slots got=%h want=%h", {mio_attr_o, dio_attr_o}, {exp_mio, exp_dio}); else pass_cnt++;
      write_ack(1'b1, 6'd0, 10'h1E7, 1'b0, 10'h0E7, "dio0");
      exp_dio[0 +: AttrDw] = 10'h0E7;
      chk_cnt++; if (dio_attr_o !== exp_dio) $display("FAIL dio0_slots got=%h want=%h", dio_attr_o, exp_dio); else pass_cnt++;
   endtask

   task automatic test_sweep_ignored();
      req_valid_i = 1'b1; req_is_dio_i = 1'b0; req_idx_i = 6'd31; req_attr_i = 10'h1F0;
      tick();
      req_valid_i = 1'b0;
      sweep_start_i = 1'b1;
      tick();
      sweep_start_i = 1'b0;
      wait_rsp_ack("busy_sweep", 1'b0, 10'h0F0);
      exp_mio[31*AttrDw +: AttrDw] = 10'h0F0;
      tick();
      chk_cnt++; if (busy_o !== 1'b0) $display("FAIL sweep_not_queued busy got=%b want=0", busy_o); else pass_cnt++;
      chk_cnt++; if (mio_attr_o !== exp_mio) $display("FAIL busy_sweep_slots got=%h want=%h", mio_attr_o, exp_mio); else pass_cnt++;
   endtask

   task automatic test_sweep();
      int n = 0;
      sweep_start_i = 1'b1; req_valid_i = 1'b1; req_is_dio_i = 1'b0; req_idx_i = 6'd7; req_attr_i = 10'h012;
      #1;
      chk_cnt++; if (req_ready_o !== 1'b0) $display("FAIL sweep_ready_block got=%b want=0", req_ready_o); else pass_cnt++;
      tick();
      sweep_start_i = 1'b0;
      while (busy_o && !sweep_done_o && n < 100) begin n++; tick(); end
      set_defaults();
      chk_cnt++; if (n !== 47) $display("FAIL sweep_cycles got=%0d want=47", n); else pass_cnt++;
      chk_cnt++; if ({sweep_done_o, busy_o, rsp_valid_o} !== 3'b100) $display("FAIL sweep_done got=%b want=100", {sweep_done_o, busy_o, rsp_valid_o}); else pass_cnt++;
      chk_cnt++; if ({mio_attr_o, dio_attr_o} !== {exp_mio, exp_dio}) $display("FAIL sweep_slots got=%h want=%h", {mio_attr_o, dio_attr_o}, {exp_mio, exp_dio}); else pass_cnt++;
      tick();
      req_valid_i = 1'b0;
      exp_mio[7*AttrDw +: AttrDw] = 10'h012;
      chk_cnt++; if ({sweep_done_o, busy_o} !== 2'b01) $display("FAIL sweep_done_once got done=%b busy=%b want done=0 busy=1", sweep_done_o, busy_o); else pass_cnt++;
      chk_cnt++; if (mio_attr_o !== exp_mio) $display("FAIL post_sweep_write got=%h want=%h", mio_attr_o, exp_mio); else pass_cnt++;
      wait_rsp_ack("post_sweep", 1'b0, 10'h012);
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      req_valid_i = 1'b1; req_is_dio_i = 1'b0; req_idx_i = 6'd3; req_attr_i = 10'h0AB;
      tick();
      req_valid_i = 1'b0;
      tick();
      exp_mio[3*AttrDw +: AttrDw] = 10'h0AB;
      chk_cnt++; if ({busy_o, mio_attr_o} !== {1'b1, exp_mio}) $display("FAIL rst_mid_pre got busy=%b mio=%h want busy=1 mio=%h", busy_o, mio_attr_o, exp_mio); else pass_cnt++;
      #2;
      rst_ni = 1'b0;
      #1;
      set_defaults();
      chk_cnt++; if ({mio_attr_o, dio_attr_o} !== {exp_mio, exp_dio}) $display("FAIL rst_mid_slots got=%h want=%h", {mio_attr_o, dio_attr_o}, {exp_mio, exp_dio}); else pass_cnt++;
      chk_cnt++; if ({busy_o, rsp_valid_o} !== 2'b00) $display("FAIL rst_mid_ctrl got=%b want=00", {busy_o, rsp_valid_o}); else pass_cnt++;
      tick();
      rst_ni = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rsp_valid_o || sweep_done_o || busy_o) bad++;
      end
      chk_cnt++; if (bad !== 0) $display("FAIL rst_mid_no_rsp got=%0d want=0 active cycles", bad); else pass_cnt++;
   endtask

`ifdef PAD_ATTR_SEQ_LOCK_EN
   task automatic test_lock();
      chk_cnt++; if (locked_o !== 1'b0) $display("FAIL lock_initial got=%b want=0", locked_o); else pass_cnt++;
      lock_i = 1'b1;
      tick();
      lock_i = 1'b0;
      tick();
      chk_cnt++; if (locked_o !== 1'b1) $display("FAIL lock_sticky got=%b want=1", locked_o); else pass_cnt++;
      req_valid_i = 1'b1; req_is_dio_i = 1'b0; req_idx_i = 6'd2; req_attr_i = 10'h001;
      tick();
      req_valid_i = 1'b0;
      chk_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_attr_o} !== {2'b11, DefM}) $display("FAIL lock_rsp got v=%b e=%b a=%h want 1 1 %h", rsp_valid_o, rsp_err_o, rsp_attr_o, DefM); else pass_cnt++;
      chk_cnt++; if (mio_attr_o !== exp_mio) $display("FAIL lock_slots got=%h want=%h", mio_attr_o, exp_mio); else pass_cnt++;
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      sweep_start_i = 1'b1;
      tick();
      sweep_start_i = 1'b0;
      chk_cnt++; if (busy_o !== 1'b0) $display("FAIL lock_sweep_ignored busy got=%b want=0", busy_o); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_mio_write();
      test_dio_err();
      test_dio_write();
      test_sweep_ignored();
      test_sweep();
      test_reset_mid();
`ifdef PAD_ATTR_SEQ_LOCK_EN
      test_lock();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=hang want=finish");
      $fatal(1, "timeout");
   end
endmodule
